// File: rtl/clk_switch_ctrl.sv
// 33 MHz clock-source sequencer: qualifies the LPC clock and steps every source change
// through a gated window so the downstream mux only ever switches while its output is off.
module clk_switch_ctrl #(
  parameter int unsigned LOSS_CYCLES = 16,
  parameter int unsigned QUAL_EDGES  = 64,
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       MCLK_FPGA,
  input  logic       HARD_nRESETi,
  input  logic       LpcClkTgl,
  input  logic       ForceOsc,
  input  logic       LossClr,
  output logic       bSelLpc,
  output logic       bClkGate,
  output logic       bLpcClkOff,
  output logic       bSwitchBusy,
  output logic [7:0] LossCnt,
  output logic [2:0] StateOut
);

  typedef enum logic [2:0] {
    StOscRun    = 3'd0,
    StQualify   = 3'd1,
    StGateToLpc = 3'd2,
    StLpcRun    = 3'd3,
    StGateToOsc = 3'd4
  } state_e;

  localparam logic [7:0] LossLim  = 8'(LOSS_CYCLES);
  localparam logic [7:0] QualLast = 8'(QUAL_EDGES - 1);
  localparam logic [3:0] GateLast = 4'(GATE_CYCLES - 1);

  state_e     stateQ, stateD;
  logic [2:0] syncQ;
  logic [7:0] idleCntQ;
  logic [7:0] qualCntQ, qualCntD;
  logic [3:0] gateCntQ, gateCntD;
  logic       selLpcQ, selLpcD;
  logic       clkGateQ, clkGateD;
  logic [7:0] lossCntQ, lossCntD;
  logic       act;
  logic       lpcAlive;

  // syncQ[0] is the metastability-catching stage; Act is an edge of the settled stages.
  assign act      = syncQ[1] ^ syncQ[2];
  assign lpcAlive = (idleCntQ < LossLim);

  always_ff @(posedge MCLK_FPGA or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      syncQ    <= 3'b000;
      idleCntQ <= 8'd0;
    end else begin
      syncQ <= {syncQ[1:0], LpcClkTgl};
      if (act) begin
        idleCntQ <= 8'd0;
      end else if (idleCntQ < LossLim) begin
        idleCntQ <= idleCntQ + 8'd1;
      end
    end
  end

  always_ff @(posedge MCLK_FPGA or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      stateQ   <= StOscRun;
      qualCntQ <= 8'd0;
      gateCntQ <= 4'd0;
      selLpcQ  <= 1'b0;
      clkGateQ <= 1'b0;
      lossCntQ <= 8'd0;
    end else begin
      stateQ   <= stateD;
      qualCntQ <= qualCntD;
      gateCntQ <= gateCntD;
      selLpcQ  <= selLpcD;
      clkGateQ <= clkGateD;
      lossCntQ <= lossCntD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    qualCntD = qualCntQ;
    gateCntD = gateCntQ;
    selLpcD  = selLpcQ;
    clkGateD = clkGateQ;
    // Clear takes effect before any same-cycle increment.
    lossCntD = LossClr ? 8'd0 : lossCntQ;

    case (stateQ)
      StOscRun: begin
        if (act && !ForceOsc) begin
          stateD   = StQualify;
          qualCntD = 8'd1;
        end
      end
      StQualify: begin
        if (ForceOsc || !lpcAlive) begin
          stateD   = StOscRun;
          qualCntD = 8'd0;
        end else if (act) begin
          if (qualCntQ == QualLast) begin
            stateD   = StGateToLpc;
            qualCntD = 8'd0;
            clkGateD = 1'b1;
            gateCntD = 4'd0;
          end else begin
            qualCntD = qualCntQ + 8'd1;
          end
        end
      end
      StGateToLpc, StGateToOsc: begin
        // Gate window runs to completion regardless of force, loss or clear.
        if (gateCntQ == 4'd1) begin
          selLpcD = (stateQ == StGateToLpc);
        end
        if (gateCntQ == GateLast) begin
          stateD   = (stateQ == StGateToLpc) ? StLpcRun : StOscRun;
          clkGateD = 1'b0;
          gateCntD = 4'd0;
        end else begin
          gateCntD = gateCntQ + 4'd1;
        end
      end
      StLpcRun: begin
        if (!lpcAlive || ForceOsc) begin
          stateD   = StGateToOsc;
          clkGateD = 1'b1;
          gateCntD = 4'd0;
          if (!lpcAlive && (lossCntD != 8'hFF)) begin
            lossCntD = lossCntD + 8'd1;
          end
        end
      end
      default: begin
        stateD   = StOscRun;
        selLpcD  = 1'b0;
        clkGateD = 1'b0;
        gateCntD = 4'd0;
        qualCntD = 8'd0;
      end
    endcase
  end

  assign bSelLpc     = selLpcQ;
  assign bClkGate    = clkGateQ;
  assign bLpcClkOff  = ~selLpcQ;
  assign bSwitchBusy = (stateQ == StGateToLpc) || (stateQ == StGateToOsc);
  assign LossCnt     = lossCntQ;
  assign StateOut    = stateQ;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed scenarios then random traffic, checked every cycle
// against a behavioural model of the selection rules.
module tb_clk_switch_ctrl;

  localparam int LOSS = 16;
  localparam int QUAL = 64;
  localparam int GATE = 4;
  localparam int MOSC = 0, MQUAL = 1, MG2L = 2, MLPC = 3, MG2O = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       tgl = 1'b0;
  logic       forceOsc = 1'b0;
  logic       lossClr = 1'b0;
  logic       bSelLpc, bClkGate, bLpcClkOff, bSwitchBusy;
  logic [7:0] lossCnt;
  logic [2:0] stateOut;

  int checks = 0;
  int errors = 0;

  // Model state: mode, idle age, accepted Act count, cycles into gate window, loss count.
  int mMode, mIdle, mQual, mAge, mLoss;
  bit ms1, ms2, ms3;

  int tglPeriod = 0, tglCnt = 0;
  bit armClr = 0, rndClr = 0;
  int gateRun = 0, lastGate = 0;
  bit gateSeen = 0;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .LOSS_CYCLES(LOSS),
    .QUAL_EDGES (QUAL),
    .GATE_CYCLES(GATE)
  ) dut (
    .MCLK_FPGA   (clk),
    .HARD_nRESETi(rstN),
    .LpcClkTgl   (tgl),
    .ForceOsc    (forceOsc),
    .LossClr     (lossClr),
    .bSelLpc     (bSelLpc),
    .bClkGate    (bClkGate),
    .bLpcClkOff  (bLpcClkOff),
    .bSwitchBusy (bSwitchBusy),
    .LossCnt     (lossCnt),
    .StateOut    (stateOut)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mMode = MOSC; mIdle = 0; mQual = 0; mAge = 0; mLoss = 0;
    ms1 = 0; ms2 = 0; ms3 = 0;
  endtask

  task automatic model_edge(input bit tglIn, input bit forceIn, input bit clrIn);
    bit act   = ms2 ^ ms3;
    bit alive = (mIdle < LOSS);
    int nMode = mMode;
    if (clrIn) mLoss = 0;
    if (mMode == MOSC) begin
      if (act && !forceIn) begin nMode = MQUAL; mQual = 1; end
    end else if (mMode == MQUAL) begin
      if (forceIn || !alive) begin
        nMode = MOSC; mQual = 0;
      end else if (act) begin
        mQual++;
        if (mQual == QUAL) begin nMode = MG2L; mAge = 0; mQual = 0; end
      end
    end else if (mMode == MG2L || mMode == MG2O) begin
      if (mAge == GATE - 1) nMode = (mMode == MG2L) ? MLPC : MOSC;
      else mAge++;
    end else if (mMode == MLPC) begin
      if (!alive) begin
        nMode = MG2O; mAge = 0;
        mLoss = (mLoss >= 255) ? 255 : mLoss + 1;
      end else if (forceIn) begin
        nMode = MG2O; mAge = 0;
      end
    end
    mIdle = act ? 0 : ((mIdle + 1 > LOSS) ? LOSS : mIdle + 1);
    ms3 = ms2; ms2 = ms1; ms1 = tglIn;
    mMode = nMode;
  endtask

  task automatic check_all();
    bit expSel, expGate;
    expGate = (mMode == MG2L) || (mMode == MG2O);
    expSel  = (mMode == MLPC) || (mMode == MG2L && mAge >= 2) || (mMode == MG2O && mAge < 2);
    chk("StateOut", {5'b0, stateOut}, 8'(mMode));
    chk("bSelLpc", {7'b0, bSelLpc}, {7'b0, expSel});
    chk("bClkGate", {7'b0, bClkGate}, {7'b0, expGate});
    chk("bLpcClkOff", {7'b0, bLpcClkOff}, {7'b0, !expSel});
    chk("bSwitchBusy", {7'b0, bSwitchBusy}, {7'b0, expGate});
    chk("LossCnt", lossCnt, 8'(mLoss));
  endtask

  task automatic step();
    if (tglPeriod != 0) begin
      tglCnt++;
      if (tglCnt >= tglPeriod) begin tgl = ~tgl; tglCnt = 0; end
    end
    lossClr = (armClr && rstN && mMode == MLPC && mIdle >= LOSS) ||
              (rndClr && $urandom_range(0, 31) == 0);
    if (lossClr && armClr) armClr = 0;
    @(posedge clk);
    if (!rstN) model_reset();
    else model_edge(tgl, forceOsc, lossClr);
    #1;
    if (bClkGate === 1'b1) begin
      gateRun++; gateSeen = 1;
    end else if (gateRun > 0) begin
      lastGate = gateRun; gateRun = 0;
    end
    check_all();
  endtask

  task automatic run_until(input int mode, input int budget, input string tag);
    int n = 0;
    while (mMode != mode && n < budget) begin step(); n++; end
    checks++;
    assert (mMode == mode) else begin
      errors++;
      $error("FAIL %s: timeout after %0d cycles, mode %0d expected %0d", tag, n, mMode, mode);
    end
  endtask

  task automatic loss_cycle();
    tglPeriod = 1;
    run_until(MLPC, 200, "satQualify");
    tglPeriod = 0;
    run_until(MOSC, 60, "satLoss");
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    @(posedge clk); #1;
    rstN = 1'b1;

    // Qualify with a toggle every 2 cycles, then run on LPC.
    tglPeriod = 2;
    run_until(MQUAL, 20, "enterQualify");
    run_until(MLPC, 400, "reachLpc");
    chk("gateWidth", 8'(lastGate), 8'(GATE));
    repeat (5) step();

    // LPC activity stops: counted loss.
    tglPeriod = 0;
    run_until(MG2O, 40, "lossExit");
    repeat (GATE) step();
    chk("lossOne", lossCnt, 8'd1);
    chk("offAfterLoss", {7'b0, bLpcClkOff}, 8'd1);
    tglPeriod = 2;
    run_until(MLPC, 400, "requalify");

    // Firmware force: uncounted exit, then held in OSC_RUN.
    forceOsc = 1'b1;
    step();
    chk("forceGateRise", {7'b0, bClkGate}, 8'd1);
    step();
    chk("forceSelHeld", {7'b0, bSelLpc}, 8'd1);
    step();
    chk("forceSelDrop", {7'b0, bSelLpc}, 8'd0);
    repeat (300) step();
    chk("forceHold", {5'b0, stateOut}, 8'd0);
    chk("forceNoCount", lossCnt, 8'd1);

    // Activity dies part-way through qualification.
    forceOsc = 1'b0;
    gateSeen = 0;
    run_until(MQUAL, 20, "qualAgain");
    for (int n = 0; n < 200 && mQual < 30; n++) step();
    tglPeriod = 0;
    run_until(MOSC, 40, "qualAbort");
    chk("noGateInQual", {7'b0, gateSeen}, 8'd0);

    // Drive the loss counter into saturation, then clear coincident with a loss.
    for (int n = 0; n < 300 && mLoss < 255; n++) loss_cycle();
    chk("lossSat", lossCnt, 8'd255);
    loss_cycle();
    chk("lossSatHold", lossCnt, 8'd255);
    armClr = 1;
    loss_cycle();
    chk("clrWithLoss", lossCnt, 8'd1);

    // Reset while GATE_TO_LPC is two cycles in.
    tglPeriod = 2;
    run_until(MG2L, 400, "toGate");
    for (int n = 0; n < 5 && mAge < 2; n++) step();
    chk("midGateHigh", {7'b0, bClkGate}, 8'd1);
    #2;
    rstN = 1'b0;
    model_reset();
    #1;
    chk("rstGate", {7'b0, bClkGate}, 8'd0);
    chk("rstSel", {7'b0, bSelLpc}, 8'd0);
    chk("rstState", {5'b0, stateOut}, 8'd0);
    gateRun = 0;
    repeat (3) step();
    rstN = 1'b1;
    run_until(MLPC, 400, "afterReset");

    // Random traffic.
    rndClr = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        tglPeriod = $urandom_range(0, 4);
        forceOsc  = ($urandom_range(0, 5) == 0);
        armClr    = $urandom_range(0, 1);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencer for the board's 33 MHz clock-source selection. It runs on the oscillator clock and watches an activity toggle from the LPC clock domain. It qualifies the LPC clock before handing the system over to it, and sequences every source change through a gated window so the downstream clock mux never switches while its output is enabled. It also counts LPC clock losses and honours a firmware force-to-oscillator override.

## Interface
- LOSS_CYCLES, 16: MCLK_FPGA cycles with no LPC activity that declare the LPC clock lost (range 4..255).
- QUAL_EDGES, 64: consecutive activity pulses required in QUALIFY before switching to LPC (range 2..255).
- GATE_CYCLES, 4: length of the gate window, in cycles, per switch (range 3..15).
- MCLK_FPGA  in  1  33 MHz oscillator clock; the only clock of this block.
- HARD_nRESETi  in  1  reset; asynchronous assert, active-low.
- LpcClkTgl  in  1  toggles once per LPC clock edge group; asynchronous to MCLK_FPGA.
- ForceOsc  in  1  level; firmware forces the oscillator source.
- LossClr  in  1  single-cycle pulse; clears LossCnt.
- bSelLpc  out  1  mux select: 1 = LPC clock, 0 = oscillator.
- bClkGate  out  1  1 = downstream clock output gated off.
- bLpcClkOff  out  1  status; equals ~bSelLpc.
- bSwitchBusy  out  1  1 while in a GATE state.
- LossCnt  out  8  count of LPC losses seen in LPC_RUN; saturates at 255.
- StateOut  out  3  current state encoding.

## Operation
- Reset is asynchronous and active-low. Reset values: state OSC_RUN, bSelLpc=0, bClkGate=0, bLpcClkOff=1, bSwitchBusy=0, LossCnt=0, StateOut=0. Synchronizer, IdleCnt, QualCnt and GateCnt all clear to 0.
- Synchronizer: LpcClkTgl passes through 3 flops (s1,s2,s3). Act = s2 ^ s3, a one-cycle pulse.
- IdleCnt (8-bit): 0 on Act; otherwise +1, saturating at LOSS_CYCLES. LpcAlive = (IdleCnt < LOSS_CYCLES).
- States and StateOut encodings: OSC_RUN=0, QUALIFY=1, GATE_TO_LPC=2, LPC_RUN=3, GATE_TO_OSC=4.
- OSC_RUN → QUALIFY on Act && !ForceOsc. QualCnt is set to 1 on entry.
- QUALIFY behaviour:
  - ForceOsc or !LpcAlive → OSC_RUN, QualCnt=0.
  - Otherwise QualCnt increments on each Act.
  - Act while QualCnt==QUAL_EDGES-1 → GATE_TO_LPC.
- GATE_TO_LPC and GATE_TO_OSC behaviour:
  - On entry, bClkGate=1 and GateCnt=0. GateCnt increments each cycle.
  - bSelLpc flips on the edge where GateCnt goes 1→2. This guarantees at least 1 gated cycle before and after the select change.
  - On GateCnt==GATE_CYCLES-1, go to LPC_RUN or OSC_RUN respectively, with bClkGate=0 on that same edge.
- The gate sequence always completes. ForceOsc, loss and LossClr do not abort it. Only reset aborts it.
- LPC_RUN → GATE_TO_OSC on !LpcAlive (LossCnt+1, saturating) or on ForceOsc (no count). If both hold, the exit is counted as a loss.
- Loss arising during GATE_TO_LPC is not counted there. LPC_RUN detects it on its first cycle and exits with a count.
- LossClr together with an increment: clear is applied first, so LossCnt=1.
- All outputs are registered. bLpcClkOff and bSwitchBusy are derived from registered state/select, so they carry no combinational path from inputs.

## Timing
- Act lags a LpcClkTgl transition by 2–3 MCLK_FPGA cycles.
- Loss detection occurs LOSS_CYCLES cycles after the last Act. With the default of 16, IdleCnt reaches 16 and LPC_RUN exits on the next edge.
- Minimum OSC→LPC latency: QUAL_EDGES Act pulses, plus GATE_CYCLES cycles.
- Gate window: bClkGate is high for exactly GATE_CYCLES cycles. bSelLpc changes 2 cycles after bClkGate rises and GATE_CYCLES-2 cycles before it falls.
- ForceOsc in LPC_RUN: bClkGate rises on the next edge, and bSelLpc=0 two edges after that.
- Reset mid-gate: outputs return to reset values immediately and asynchronously.

## Test plan
- LpcClkTgl toggling every 2 cycles, ForceOsc=0, defaults → QUALIFY after the first Act; bClkGate high for exactly 4 cycles; bSelLpc rises on the 3rd gated cycle; StateOut=3; LossCnt=0.
- In LPC_RUN, freeze LpcClkTgl → after 16 idle cycles: GATE_TO_OSC, bSelLpc=0, LossCnt=1, bLpcClkOff=1. Resume toggling → re-qualifies after 64 Acts.
- Assert ForceOsc in LPC_RUN → switch to OSC with LossCnt unchanged. Keep ForceOsc high with LPC toggling → stays in OSC_RUN indefinitely.
- Stop LPC activity after 30 Acts in QUALIFY → OSC_RUN, bClkGate never asserted, QualCnt=0.
- Force 256 loss cycles (toggle, qualify, stop, repeated) → LossCnt saturates at 255. LossClr coincident with the next loss → LossCnt=1.
- Assert HARD_nRESETi low during GATE_TO_LPC (GateCnt=2) → bClkGate=0, bSelLpc=0, StateOut=0 immediately. Release reset → normal qualification restarts.
